// File: rtl/gpu_pkg.sv
// Shared GPU core encodings: core pipeline states and per-thread LSU states.
package gpu_pkg;

   typedef enum logic [2:0] {
      CORE_IDLE    = 3'b000,
      CORE_FETCH   = 3'b001,
      CORE_DECODE  = 3'b010,
      CORE_REQUEST = 3'b011,
      CORE_WAIT    = 3'b100,
      CORE_EXECUTE = 3'b101,
      CORE_UPDATE  = 3'b110,
      CORE_DONE    = 3'b111
   } core_state_t;

   typedef enum logic [1:0] {
      LSU_IDLE       = 2'd0,
      LSU_REQUESTING = 2'd1,
      LSU_WAITING    = 2'd2,
      LSU_DONE       = 2'd3
   } lsu_state_t;

   localparam int NUM_STATS = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping; clear has priority.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (clear)
         count_reg <= '0;
      else if (inc && (count_reg != '1))
         count_reg <= count_reg + WIDTH'(1);
   end

   assign count = count_reg;

endmodule

// File: rtl/thread_lsu.sv
// Per-thread load/store unit bridging decoded LDR/STR to one memory-controller port.
// Optional statistics counters are built when LSU_STATS_EN is defined.
module thread_lsu
   import gpu_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 16,
   parameter int STAT_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2:0]           core_state,
   input  logic                 decoded_mem_read,
   input  logic                 decoded_mem_write,
   input  logic [DATA_BITS-1:0] rs,
   input  logic [DATA_BITS-1:0] rt,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   input  logic                 mem_read_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_BITS-1:0] mem_write_data,
   input  logic                 mem_write_ready,
   output logic [1:0]           lsu_state,
   output logic [DATA_BITS-1:0] lsu_out,
   output logic [STAT_BITS-1:0] stat_loads,
   output logic [STAT_BITS-1:0] stat_stores,
   output logic [STAT_BITS-1:0] stat_wait_cycles
);

   lsu_state_t           state_reg, state_next;
   logic                 is_read_reg, is_read_next;
   logic                 read_valid_reg, read_valid_next;
   logic [ADDR_BITS-1:0] read_addr_reg, read_addr_next;
   logic                 write_valid_reg, write_valid_next;
   logic [ADDR_BITS-1:0] write_addr_reg, write_addr_next;
   logic [DATA_BITS-1:0] write_data_reg, write_data_next;
   logic [DATA_BITS-1:0] out_reg, out_next;

   // Upper address-operand bits are intentionally discarded.
   logic unused_rs_bits;
   assign unused_rs_bits = ^rs[DATA_BITS-1:ADDR_BITS];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= LSU_IDLE;
         is_read_reg     <= 1'b0;
         read_valid_reg  <= 1'b0;
         read_addr_reg   <= '0;
         write_valid_reg <= 1'b0;
         write_addr_reg  <= '0;
         write_data_reg  <= '0;
         out_reg         <= '0;
      end else begin
         state_reg       <= state_next;
         is_read_reg     <= is_read_next;
         read_valid_reg  <= read_valid_next;
         read_addr_reg   <= read_addr_next;
         write_valid_reg <= write_valid_next;
         write_addr_reg  <= write_addr_next;
         write_data_reg  <= write_data_next;
         out_reg         <= out_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      is_read_next     = is_read_reg;
      read_valid_next  = read_valid_reg;
      read_addr_next   = read_addr_reg;
      write_valid_next = write_valid_reg;
      write_addr_next  = write_addr_reg;
      write_data_next  = write_data_reg;
      out_next         = out_reg;
      if (enable) begin
         case (state_reg)
            LSU_IDLE: begin
               // Operation is latched here; a simultaneous read and write resolves to read.
               if ((core_state == CORE_REQUEST) && (decoded_mem_read || decoded_mem_write)) begin
                  is_read_next = decoded_mem_read;
                  state_next   = LSU_REQUESTING;
               end
            end
            LSU_REQUESTING: begin
               if (is_read_reg) begin
                  read_valid_next = 1'b1;
                  read_addr_next  = rs[ADDR_BITS-1:0];
               end else begin
                  write_valid_next = 1'b1;
                  write_addr_next  = rs[ADDR_BITS-1:0];
                  write_data_next  = rt;
               end
               state_next = LSU_WAITING;
            end
            LSU_WAITING: begin
               if (is_read_reg) begin
                  if (mem_read_ready) begin
                     out_next        = mem_read_data;
                     read_valid_next = 1'b0;
                     state_next      = LSU_DONE;
                  end
               end else if (mem_write_ready) begin
                  write_valid_next = 1'b0;
                  state_next       = LSU_DONE;
               end
            end
            LSU_DONE: begin
               if (core_state == CORE_UPDATE)
                  state_next = LSU_IDLE;
            end
            default: state_next = LSU_IDLE;
         endcase
      end
   end

   assign mem_read_valid    = read_valid_reg;
   assign mem_read_address  = read_addr_reg;
   assign mem_write_valid   = write_valid_reg;
   assign mem_write_address = write_addr_reg;
   assign mem_write_data    = write_data_reg;
   assign lsu_state         = state_reg;
   assign lsu_out           = out_reg;

`ifdef LSU_STATS_EN
   logic [NUM_STATS-1:0] stat_inc;
   logic [STAT_BITS-1:0] stat_count [NUM_STATS];
   logic                 waiting;

   assign waiting     = enable && (state_reg == LSU_WAITING);
   assign stat_inc[0] = waiting && is_read_reg && mem_read_ready;
   assign stat_inc[1] = waiting && !is_read_reg && mem_write_ready;
   assign stat_inc[2] = waiting;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_STATS; gi++) begin : g_stat
         sat_counter #(.WIDTH(STAT_BITS)) u_cnt (
            .clk   (clk),
            .clear (reset),
            .inc   (stat_inc[gi]),
            .count (stat_count[gi])
         );
      end
   endgenerate

   assign stat_loads       = stat_count[0];
   assign stat_stores      = stat_count[1];
   assign stat_wait_cycles = stat_count[2];
`else
   assign stat_loads       = '0;
   assign stat_stores      = '0;
   assign stat_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_thread_lsu.sv
// Self-checking bench for thread_lsu: directed vector table, corner sequences, random transactions.
module tb_thread_lsu;

   localparam int AB = 8;
   localparam int DB = 16;
   localparam int SB = 2;
   localparam int SAT_MAX = 3;

   localparam logic [2:0] C_IDLE    = 3'b000;
   localparam logic [2:0] C_REQUEST = 3'b011;
   localparam logic [2:0] C_WAIT    = 3'b100;
   localparam logic [2:0] C_EXECUTE = 3'b101;
   localparam logic [2:0] C_UPDATE  = 3'b110;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [2:0]    core_state;
   logic          decoded_mem_read;
   logic          decoded_mem_write;
   logic [DB-1:0] rs;
   logic [DB-1:0] rt;
   logic          mem_read_valid;
   logic [AB-1:0] mem_read_address;
   logic          mem_read_ready;
   logic [DB-1:0] mem_read_data;
   logic          mem_write_valid;
   logic [AB-1:0] mem_write_address;
   logic [DB-1:0] mem_write_data;
   logic          mem_write_ready;
   logic [1:0]    lsu_state;
   logic [DB-1:0] lsu_out;
   logic [SB-1:0] stat_loads;
   logic [SB-1:0] stat_stores;
   logic [SB-1:0] stat_wait_cycles;

   thread_lsu #(.ADDR_BITS(AB), .DATA_BITS(DB), .STAT_BITS(SB)) dut (
      .clk               (clk),
      .reset             (reset),
      .enable            (enable),
      .core_state        (core_state),
      .decoded_mem_read  (decoded_mem_read),
      .decoded_mem_write (decoded_mem_write),
      .rs                (rs),
      .rt                (rt),
      .mem_read_valid    (mem_read_valid),
      .mem_read_address  (mem_read_address),
      .mem_read_ready    (mem_read_ready),
      .mem_read_data     (mem_read_data),
      .mem_write_valid   (mem_write_valid),
      .mem_write_address (mem_write_address),
      .mem_write_data    (mem_write_data),
      .mem_write_ready   (mem_write_ready),
      .lsu_state         (lsu_state),
      .lsu_out           (lsu_out),
      .stat_loads        (stat_loads),
      .stat_stores       (stat_stores),
      .stat_wait_cycles  (stat_wait_cycles)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: what each observable should be, tracked per transaction.
   logic [AB-1:0] m_raddr, m_waddr;
   logic [DB-1:0] m_wdata, m_out;
   int            m_loads, m_stores, m_waits;

   typedef struct {
      logic          rd;
      logic          wr;
      logic [DB-1:0] rs;
      logic [DB-1:0] rt;
      logic [DB-1:0] rdata;
      int            delay;
      logic [AB-1:0] exp_addr;
      bit            exp_read;
   } vec_t;

   vec_t vecs [5];

   function automatic int sat_inc(int v);
      return (v >= SAT_MAX) ? SAT_MAX : v + 1;
   endfunction

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_raddr = '0; m_waddr = '0; m_wdata = '0; m_out = '0;
      m_loads = 0; m_stores = 0; m_waits = 0;
   endtask

   task automatic check_all(input string tag, input int st, input bit rv, input bit wv);
      chk({tag, ".state"}, lsu_state, st);
      chk({tag, ".rvalid"}, mem_read_valid, rv);
      chk({tag, ".wvalid"}, mem_write_valid, wv);
      chk({tag, ".raddr"}, mem_read_address, m_raddr);
      chk({tag, ".waddr"}, mem_write_address, m_waddr);
      chk({tag, ".wdata"}, mem_write_data, m_wdata);
      chk({tag, ".out"}, lsu_out, m_out);
`ifdef LSU_STATS_EN
      chk({tag, ".loads"}, stat_loads, m_loads);
      chk({tag, ".stores"}, stat_stores, m_stores);
      chk({tag, ".waits"}, stat_wait_cycles, m_waits);
`else
      chk({tag, ".loads"}, stat_loads, 0);
      chk({tag, ".stores"}, stat_stores, 0);
      chk({tag, ".waits"}, stat_wait_cycles, 0);
`endif
   endtask

   // One full LDR/STR: request, 'delay' idle wait cycles, handshake, DONE hold, UPDATE.
   task automatic run_txn(input vec_t v, input string tag);
      bit rd_op;
      rd_op = v.exp_read;
      enable = 1'b1;
      core_state = C_REQUEST;
      decoded_mem_read = v.rd;
      decoded_mem_write = v.wr;
      rs = v.rs;
      rt = v.rt;
      tick();
      check_all({tag, ".req"}, 1, 1'b0, 1'b0);
      core_state = C_WAIT;
      decoded_mem_read = 1'b0;
      decoded_mem_write = 1'b0;
      tick();
      if (rd_op) m_raddr = v.exp_addr;
      else begin
         m_waddr = v.exp_addr;
         m_wdata = v.rt;
      end
      check_all({tag, ".valid"}, 2, rd_op, !rd_op);
      for (int i = 0; i < v.delay; i++) begin
         // Ready of the opposite direction must be ignored.
         mem_read_ready = !rd_op;
         mem_write_ready = rd_op;
         mem_read_data = DB'($urandom);
         tick();
         m_waits = sat_inc(m_waits);
         check_all({tag, ".hold"}, 2, rd_op, !rd_op);
      end
      mem_read_ready = rd_op;
      mem_write_ready = !rd_op;
      mem_read_data = v.rdata;
      tick();
      m_waits = sat_inc(m_waits);
      if (rd_op) begin
         m_out = v.rdata;
         m_loads = sat_inc(m_loads);
      end else begin
         m_stores = sat_inc(m_stores);
      end
      check_all({tag, ".ack"}, 3, 1'b0, 1'b0);
      mem_read_ready = 1'b0;
      mem_write_ready = 1'b0;
      mem_read_data = 16'h5A5A;
      core_state = C_EXECUTE;
      tick();
      check_all({tag, ".done"}, 3, 1'b0, 1'b0);
      core_state = C_UPDATE;
      tick();
      check_all({tag, ".upd"}, 0, 1'b0, 1'b0);
      core_state = C_IDLE;
      $display("txn %s rd=%0b wr=%0b rs=%h rt=%h rdata=%h delay=%0d", tag, v.rd, v.wr, v.rs, v.rt, v.rdata, v.delay);
   endtask

   initial begin
      vec_t rv;
      vecs[0] = '{rd:1'b1, wr:1'b0, rs:16'h0112, rt:16'h0000, rdata:16'h00AB, delay:3, exp_addr:8'h12, exp_read:1'b1};
      vecs[1] = '{rd:1'b0, wr:1'b1, rs:16'h0005, rt:16'hBEEF, rdata:16'h0000, delay:1, exp_addr:8'h05, exp_read:1'b0};
      vecs[2] = '{rd:1'b1, wr:1'b1, rs:16'h3377, rt:16'h1234, rdata:16'hCAFE, delay:0, exp_addr:8'h77, exp_read:1'b1};
      vecs[3] = '{rd:1'b1, wr:1'b0, rs:16'hFFFF, rt:16'h0000, rdata:16'h0000, delay:0, exp_addr:8'hFF, exp_read:1'b1};
      vecs[4] = '{rd:1'b0, wr:1'b1, rs:16'h8000, rt:16'h0000, rdata:16'h1111, delay:2, exp_addr:8'h00, exp_read:1'b0};

      reset = 1'b1; enable = 1'b0; core_state = C_IDLE;
      decoded_mem_read = 1'b0; decoded_mem_write = 1'b0;
      rs = '0; rt = '0; mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
      model_reset();
      tick(); tick();
      reset = 1'b0;
      check_all("reset", 0, 1'b0, 1'b0);

      for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      // Disabled slot ignores a request.
      enable = 1'b0; core_state = C_REQUEST; decoded_mem_read = 1'b1; rs = 16'h0042;
      tick(); tick();
      check_all("disabled", 0, 1'b0, 1'b0);
      $display("seq disabled request");

      // Stray read ready in IDLE must not disturb lsu_out.
      enable = 1'b1; core_state = C_IDLE; decoded_mem_read = 1'b0;
      mem_read_ready = 1'b1; mem_read_data = 16'h7777;
      tick();
      mem_read_ready = 1'b0;
      check_all("stray", 0, 1'b0, 1'b0);
      $display("seq stray ready");

      // Reset in the middle of WAITING, then a late ready.
      core_state = C_REQUEST; decoded_mem_read = 1'b1; rs = 16'h0033;
      tick();
      core_state = C_WAIT; decoded_mem_read = 1'b0;
      tick();
      m_raddr = 8'h33;
      check_all("rstw.pre", 2, 1'b1, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
      check_all("rstw.rst", 0, 1'b0, 1'b0);
      mem_read_ready = 1'b1; mem_read_data = 16'h9999;
      tick();
      mem_read_ready = 1'b0;
      check_all("rstw.late", 0, 1'b0, 1'b0);
      $display("seq reset in waiting");

      // Random transactions against the model; stats saturate along the way.
      for (int i = 0; i < 24; i++) begin
         rv.rd = 1'($urandom_range(0, 1));
         rv.wr = rv.rd ? 1'($urandom_range(0, 1)) : 1'b1;
         rv.rs = DB'($urandom);
         rv.rt = DB'($urandom);
         rv.rdata = DB'($urandom);
         rv.delay = int'($urandom_range(0, 4));
         rv.exp_addr = AB'(rv.rs % (1 << AB));
         rv.exp_read = rv.rd;
         run_txn(rv, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
